// File: rtl/hdmi_link_seq_if.sv
// Status sideband bundle between the TX subsystem and the link sequencer.
//   tdata  [1:0] : bit0 = link ready, bit1 unused by the sequencer
//   tvalid       : beat valid
//   tready       : sink ready
// master = TX subsystem status source, slave = hdmi_link_seq.
interface hdmi_link_seq_if;
  logic [1:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/hdmi_link_seq.sv
// HDMI TX link bring-up sequencer.
// Qualifies link-ready from the status sideband, times out a failed lock,
// issues TX restart requests with back-off and a retry limit, and drives a
// state-coded heartbeat.
// Ports:
//   status_sb_aclk    : clock for the whole block
//   status_sb_aresetn : asynchronous active-low reset
//   status_sb         : status sideband (slave side); tready held 1 after reset
//   enable            : 1 = run sequencer, 0 = force IDLE
//   tx_restart        : one-clock restart request
//   link_up / fault   : high while in UP / FAULT
//   retry_cnt         : restarts issued since last UP/IDLE (saturates at 15)
//   hdmi_hb           : heartbeat
module hdmi_link_seq #(
  parameter int unsigned HB_DIV      = 10_000_000,
  parameter int unsigned STABLE_CYC  = 1_000_000,
  parameter int unsigned LOCK_TO_CYC = 50_000_000,
  parameter int unsigned RETRY_CYC   = 5_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                  status_sb_aclk,
  input  logic                  status_sb_aresetn,
  hdmi_link_seq_if.slave        status_sb,
  input  logic                  enable,
  output logic                  tx_restart,
  output logic                  link_up,
  output logic                  fault,
  output logic [3:0]            retry_cnt,
  output logic                  hdmi_hb
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_QUAL, S_UP, S_BACKOFF, S_FAULT
  } state_t;

  localparam logic [31:0] LOCK_END   = 32'(LOCK_TO_CYC - 1);
  localparam logic [31:0] STABLE_END = 32'(STABLE_CYC - 1);
  localparam logic [31:0] RETRY_END  = 32'(RETRY_CYC - 1);
  localparam logic [31:0] HB_SLOW    = 32'(HB_DIV - 1);
  localparam logic [31:0] HB_FAST    = 32'(HB_DIV / 4 - 1);
  localparam logic [3:0]  MAX_R      = 4'(MAX_RETRY);

  state_t      state, state_nx;
  logic        rdy_q;
  logic [31:0] timer, timer_d;
  logic [31:0] hb_cnt, hb_cnt_d;
  logic        hb_d, restart_d, link_up_d, fault_d;
  logic [3:0]  retry_d;
  logic        changed;
  logic        unused_bits;

  assign unused_bits = status_sb.tdata[1];

  // State register plus all registered outputs
  always_ff @(posedge status_sb_aclk or negedge status_sb_aresetn) begin
    if (!status_sb_aresetn) begin
      state            <= S_IDLE;
      rdy_q            <= 1'b0;
      timer            <= '0;
      hb_cnt           <= '0;
      hdmi_hb          <= 1'b0;
      tx_restart       <= 1'b0;
      link_up          <= 1'b0;
      fault            <= 1'b0;
      retry_cnt        <= '0;
      status_sb.tready <= 1'b0;
    end else begin
      state            <= state_nx;
      if (status_sb.tvalid) rdy_q <= status_sb.tdata[0];
      timer            <= timer_d;
      hb_cnt           <= hb_cnt_d;
      hdmi_hb          <= hb_d;
      tx_restart       <= restart_d;
      link_up          <= link_up_d;
      fault            <= fault_d;
      retry_cnt        <= retry_d;
      status_sb.tready <= 1'b1;
    end
  end

  // Next-state logic; enable=0 overrides every other condition
  always_comb begin
    state_nx  = state;
    restart_d = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_WAIT;
        S_WAIT: begin
          if (rdy_q)                 state_nx = S_QUAL;
          else if (timer == LOCK_END) state_nx = S_BACKOFF;
        end
        S_QUAL: begin
          if (!rdy_q)                   state_nx = S_WAIT;
          else if (timer == STABLE_END) state_nx = S_UP;
        end
        S_UP: if (!rdy_q) state_nx = S_BACKOFF;
        S_BACKOFF: begin
          if (timer == RETRY_END) begin
            if (retry_cnt == MAX_R) begin
              state_nx = S_FAULT;
            end else begin
              state_nx  = S_WAIT;
              restart_d = 1'b1;
            end
          end
        end
        S_FAULT: state_nx = S_FAULT;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output/counter logic, computed from the next state so that the
  // registered outputs line up with the state register.
  always_comb begin
    changed   = (state_nx != state);
    link_up_d = (state_nx == S_UP);
    fault_d   = (state_nx == S_FAULT);

    timer_d = changed ? '0 : ((timer == '1) ? timer : timer + 32'd1);

    if (state_nx == S_IDLE || state_nx == S_UP)
      retry_d = '0;
    else if (restart_d && retry_cnt != 4'hF)
      retry_d = retry_cnt + 4'd1;
    else
      retry_d = retry_cnt;

    hb_cnt_d = '0;
    hb_d     = hdmi_hb;
    if (changed) begin
      hb_d = (state_nx == S_FAULT);
    end else begin
      case (state)
        S_IDLE:  hb_d = 1'b0;
        S_FAULT: hb_d = 1'b1;
        S_UP: begin
          if (hb_cnt == HB_SLOW) hb_d = ~hdmi_hb;
          else                   hb_cnt_d = hb_cnt + 32'd1;
        end
        default: begin
          if (hb_cnt == HB_FAST) hb_d = ~hdmi_hb;
          else                   hb_cnt_d = hb_cnt + 32'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_link_seq.sv
module tb_hdmi_link_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       tx_restart, link_up, fault, hdmi_hb;
  logic [3:0] retry_cnt;

  hdmi_link_seq_if sb();

  hdmi_link_seq #(
    .HB_DIV(8), .STABLE_CYC(4), .LOCK_TO_CYC(16), .RETRY_CYC(6), .MAX_RETRY(2)
  ) dut (
    .status_sb_aclk    (clk),
    .status_sb_aresetn (rst_n),
    .status_sb         (sb),
    .enable            (enable),
    .tx_restart        (tx_restart),
    .link_up           (link_up),
    .fault             (fault),
    .retry_cnt         (retry_cnt),
    .hdmi_hb           (hdmi_hb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       tv;
    logic [1:0] td;
    logic [7:0] exp;   // {link_up, fault, tx_restart, retry_cnt, hdmi_hb}
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [7:0] outs();
    return {link_up, fault, tx_restart, retry_cnt, hdmi_hb};
  endfunction

  // n rows of identical inputs/flags; heartbeat expectation: div==0 -> 0,
  // div<0 -> 1, else toggling every div clocks, off = clocks already spent
  // in the state before this segment.
  task automatic seg(input int n, input logic en, input logic tv, input logic [1:0] td,
                     input logic lu, input logic fl, input logic tr, input logic [3:0] rc,
                     input int div, input int off);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      logic hb;
      if (div == 0)     hb = 1'b0;
      else if (div < 0) hb = 1'b1;
      else              hb = 1'(((off + i + 1) / div) % 2);
      v.en = en; v.tv = tv; v.td = td;
      v.exp = {lu, fl, tr, rc, hb};
      vecs.push_back(v);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: lu/fl/tr/rc/hb got %b/%b/%b/%0d/%b need %b/%b/%b/%0d/%b", name,
               act[7], act[6], act[5], act[4:1], act[0], exp[7], exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b need %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic tv, input logic [1:0] td);
    enable = en; sb.tvalid = tv; sb.tdata = td;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Bring-up, UP heartbeat, tvalid gating, two retries, FAULT, disable, re-bring-up
    seg(1, 1,1,2'd1, 0,0,0,4'd0, 0,0);   // IDLE -> WAIT
    seg(1, 1,1,2'd1, 0,0,0,4'd0, 0,0);   // WAIT -> QUAL
    seg(3, 1,1,2'd1, 0,0,0,4'd0, 2,0);   // QUAL
    seg(1, 1,1,2'd1, 1,0,0,4'd0, 0,0);   // -> UP
    seg(16,1,1,2'd1, 1,0,0,4'd0, 8,0);   // UP heartbeat
    seg(2, 1,0,2'd0, 1,0,0,4'd0, 8,16);  // tvalid=0: ignored
    seg(1, 1,1,2'd0, 1,0,0,4'd0, 8,18);  // drop captured, FSM sees it next clock
    seg(1, 1,1,2'd0, 0,0,0,4'd0, 0,0);   // -> BACKOFF
    seg(5, 1,1,2'd0, 0,0,0,4'd0, 2,0);
    seg(1, 1,1,2'd0, 0,0,1,4'd1, 0,0);   // restart #1 -> WAIT
    seg(15,1,1,2'd0, 0,0,0,4'd1, 2,0);
    seg(1, 1,1,2'd0, 0,0,0,4'd1, 0,0);   // lock timeout -> BACKOFF
    seg(5, 1,1,2'd0, 0,0,0,4'd1, 2,0);
    seg(1, 1,1,2'd0, 0,0,1,4'd2, 0,0);   // restart #2
    seg(15,1,1,2'd0, 0,0,0,4'd2, 2,0);
    seg(1, 1,1,2'd0, 0,0,0,4'd2, 0,0);
    seg(5, 1,1,2'd0, 0,0,0,4'd2, 2,0);
    seg(1, 1,1,2'd0, 0,1,0,4'd2, -1,0);  // limit reached -> FAULT, no pulse
    seg(3, 1,1,2'd0, 0,1,0,4'd2, -1,0);
    seg(1, 0,1,2'd0, 0,0,0,4'd0, 0,0);   // enable=0 -> IDLE
    seg(2, 0,1,2'd0, 0,0,0,4'd0, 0,0);
    seg(1, 1,1,2'd1, 0,0,0,4'd0, 0,0);   // re-enable
    seg(1, 1,1,2'd1, 0,0,0,4'd0, 0,0);
    seg(3, 1,1,2'd1, 0,0,0,4'd0, 2,0);
    seg(1, 1,1,2'd1, 1,0,0,4'd0, 0,0);   // UP again

    drive(0, 0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    check8("reset_outs", outs(), 8'h00);
    check1("reset_tready", sb.tready, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check1("tready_after_reset", sb.tready, 1'b1);
    check8("idle_outs", outs(), 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].tv, vecs[i].td);
      tick();
      check8($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Short ready burst: QUAL aborts, lock timer restarts from zero in WAIT
    drive(0, 1, 2'd0);
    tick(); tick();
    check8("seq1_idle", outs(), 8'h00);
    for (int e = 1; e <= 27; e++) begin
      drive(1, 1, (e <= 2) ? 2'd3 : 2'd2);
      tick();
      if (e <= 25)
        check8($sformatf("seq1_e%0d", e), {outs()[7:5], 5'b0}, 8'h00);
      else if (e == 26)
        check8("seq1_pulse", {outs()[7:1], 1'b0}, {1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
      else
        check8("seq1_after_pulse", {outs()[7:1], 1'b0}, {1'b0, 1'b0, 1'b0, 4'd1, 1'b0});
    end

    // Asynchronous reset while in BACKOFF with retry_cnt and heartbeat nonzero
    drive(0, 1, 2'd2);
    tick();
    check8("seq2_idle", outs(), 8'h00);
    for (int e = 1; e <= 41; e++) begin
      drive(1, 1, 2'd2);
      tick();
      if (e == 23) check8("seq2_pulse", outs(), {1'b0, 1'b0, 1'b1, 4'd1, 1'b0});
    end
    check8("seq2_backoff", outs(), {1'b0, 1'b0, 1'b0, 4'd1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check8("seq2_reset_outs", outs(), 8'h00);
    check1("seq2_reset_tready", sb.tready, 1'b0);
    drive(0, 1, 2'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check1("seq2_tready", sb.tready, 1'b1);
    check8("seq2_post_reset", outs(), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
